// File: rtl/mon_exp.sv
// rtl/mon_exp.sv - modular exponentiation sequencer driving a Montgomery multiplier
//
// Computes result = base^exp mod modulus by left-to-right square-and-multiply
// in the Montgomery domain (R = 2^64). Software supplies r2 = R^2 mod modulus.
//
// Ports:
//   pclk, nreset      clock, synchronous active-low reset
//   start             one-cycle pulse, accepted in IDLE or DONE
//   base, exp         operands (base < modulus)
//   modulus, r2       odd modulus > 1, R^2 mod modulus
//   result, err       final value / operand-check failure, valid while done=1
//   busy, done        run in progress / run finished
//   mm_go, mm_a,      multiplier GO and operands
//   mm_b, mm_m
//   mm_p, mm_ready    multiplier product (< 2*modulus) and ready flag
module mon_exp #(
    parameter int EXP_BITS   = 64,
    parameter int GAP_CYCLES = 1
) (
    input  logic        pclk,
    input  logic        nreset,
    input  logic        start,
    input  logic [63:0] base,
    input  logic [63:0] exp,
    input  logic [63:0] modulus,
    input  logic [63:0] r2,
    output logic [63:0] result,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mm_go,
    output logic [63:0] mm_a,
    output logic [63:0] mm_b,
    output logic [63:0] mm_m,
    input  logic [65:0] mm_p,
    input  logic        mm_ready
);

    localparam int IW = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RUN, S_GAP, S_DONE} state_t;
    typedef enum logic [2:0] {OP_CONV_X, OP_CONV_ONE, OP_SQR, OP_MUL, OP_FINAL} op_t;

    state_t              state;
    op_t                 op;
    logic [63:0]         b_r;
    logic [EXP_BITS-1:0] e_r;
    logic [63:0]         m_r;
    logic [63:0]         r2_r;
    logic [63:0]         xm;
    logic [63:0]         acc;
    logic [IW-1:0]       idx;
    logic [GW-1:0]       gap_cnt;
    logic [65:0]         q66;

    assign mm_m = m_r;

    // Multiplier output is below 2*M, so a single conditional subtraction
    // fully reduces it.
    always_comb begin
        q66 = mm_p;
        if (mm_p >= {2'b00, m_r})
            q66 = mm_p - {2'b00, m_r};
    end

    always_ff @(posedge pclk) begin
        if (!nreset) begin
            state   <= S_IDLE;
            op      <= OP_CONV_X;
            b_r     <= '0;
            e_r     <= '0;
            m_r     <= '0;
            r2_r    <= '0;
            xm      <= '0;
            acc     <= '0;
            idx     <= '0;
            gap_cnt <= '0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            mm_go   <= 1'b0;
            mm_a    <= '0;
            mm_b    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        b_r   <= base;
                        e_r   <= EXP_BITS'(exp);
                        m_r   <= modulus;
                        r2_r  <= r2;
                        done  <= 1'b0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!m_r[0] || m_r <= 64'd1 || b_r >= m_r) begin
                        err    <= 1'b1;
                        result <= '0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        op    <= OP_CONV_X;
                        mm_a  <= b_r;
                        mm_b  <= r2_r;
                        mm_go <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (mm_ready) begin
                        mm_go <= 1'b0;
                        case (op)
                            OP_CONV_X: xm     <= q66[63:0];
                            OP_FINAL:  result <= q66[63:0];
                            default:   acc    <= q66[63:0];
                        endcase
                        if (op == OP_FINAL) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            gap_cnt <= GW'(GAP_CYCLES - 1);
                            state   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end else begin
                        // Select the next operation; acc/xm already hold the
                        // previous op's result.
                        state <= S_RUN;
                        mm_go <= 1'b1;
                        case (op)
                            OP_CONV_X: begin
                                op   <= OP_CONV_ONE;
                                mm_a <= 64'd1;
                                mm_b <= r2_r;
                            end
                            OP_CONV_ONE: begin
                                op   <= OP_SQR;
                                idx  <= IW'(EXP_BITS - 1);
                                mm_a <= acc;
                                mm_b <= acc;
                            end
                            OP_SQR: begin
                                if (e_r[idx]) begin
                                    op   <= OP_MUL;
                                    mm_a <= acc;
                                    mm_b <= xm;
                                end else if (idx == '0) begin
                                    op   <= OP_FINAL;
                                    mm_a <= acc;
                                    mm_b <= 64'd1;
                                end else begin
                                    op   <= OP_SQR;
                                    idx  <= idx - IW'(1);
                                    mm_a <= acc;
                                    mm_b <= acc;
                                end
                            end
                            OP_MUL: begin
                                if (idx == '0) begin
                                    op   <= OP_FINAL;
                                    mm_a <= acc;
                                    mm_b <= 64'd1;
                                end else begin
                                    op   <= OP_SQR;
                                    idx  <= idx - IW'(1);
                                    mm_a <= acc;
                                    mm_b <= acc;
                                end
                            end
                            default: begin
                                op    <= OP_FINAL;
                                mm_go <= 1'b0;
                                state <= S_DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end
                        endcase
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (nreset && state == S_RUN && mm_ready)
            assert (q66 < {2'b00, m_r});
    end

endmodule
